// File: rtl/cell_writer.sv
// Read-modify-write of a single arena cell: read the row, update one bit, write it back,
// and report the cell's previous value.
module cell_writer #(
  parameter int unsigned ARENA_WIDTH  = 10,
  parameter int unsigned ARENA_HEIGHT = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [1:0]             op,
  input  logic [9:0]             cell_column,
  input  logic [9:0]             cell_row,
  input  logic                   cell_value,
  output logic                   done,
  output logic                   error,
  output logic                   prev_value,
  output logic                   changed,
  output logic [9:0]             arena_row_select,
  input  logic [ARENA_WIDTH-1:0] arena_columns,
  output logic                   arena_write_en,
  output logic [ARENA_WIDTH-1:0] arena_write_data
);

  typedef enum logic [2:0] {StIdle, StRead, StModify, StWrite, StError} state_e;

  localparam logic [1:0] OpWrite  = 2'd0;
  localparam logic [1:0] OpSet    = 2'd1;
  localparam logic [1:0] OpClear  = 2'd2;
  localparam logic [1:0] OpToggle = 2'd3;

  state_e                 state_q, state_d;
  logic [1:0]             op_q;
  logic [9:0]             row_q, col_q;
  logic                   value_q;
  logic [ARENA_WIDTH-1:0] old_q;

  logic [ARENA_WIDTH-1:0] mask;
  logic [ARENA_WIDTH-1:0] modify_new;
  logic [ARENA_WIDTH-1:0] write_new;
  logic                   out_of_range;

  function automatic logic [ARENA_WIDTH-1:0] apply_op(input logic [ARENA_WIDTH-1:0] row,
                                                      input logic [ARENA_WIDTH-1:0] m,
                                                      input logic [1:0]             o,
                                                      input logic                   v);
    logic [ARENA_WIDTH-1:0] r;
    r = row;
    unique case (o)
      OpWrite:  r = v ? (row | m) : (row & ~m);
      OpSet:    r = row | m;
      OpClear:  r = row & ~m;
      OpToggle: r = row ^ m;
      default:  r = row;
    endcase
    return r;
  endfunction

  // Shift instead of indexing so the 10-bit column needs no width juggling.
  assign mask         = ARENA_WIDTH'(1) << col_q;
  assign modify_new   = apply_op(arena_columns, mask, op_q, value_q);
  assign write_new    = apply_op(old_q, mask, op_q, value_q);
  assign out_of_range = (32'(cell_row) >= ARENA_HEIGHT) || (32'(cell_column) >= ARENA_WIDTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      value_q <= 1'b0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        op_q    <= op;
        row_q   <= cell_row;
        col_q   <= cell_column;
        value_q <= cell_value;
      end
      if (state_q == StModify) begin
        old_q <= arena_columns;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    ready            = 1'b0;
    done             = 1'b0;
    error            = 1'b0;
    prev_value       = 1'b0;
    changed          = 1'b0;
    arena_row_select = '0;
    arena_write_en   = 1'b0;
    arena_write_data = '0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) state_d = out_of_range ? StError : StRead;
      end
      StRead: begin
        arena_row_select = row_q;
        state_d          = StModify;
      end
      StModify: begin
        arena_row_select = row_q;
        // An update that leaves the row unchanged finishes here without a write.
        if (modify_new == arena_columns) begin
          done       = 1'b1;
          prev_value = |(arena_columns & mask);
          state_d    = StIdle;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        arena_row_select = row_q;
        arena_write_en   = 1'b1;
        arena_write_data = write_new;
        done             = 1'b1;
        changed          = 1'b1;
        prev_value       = |(old_q & mask);
        state_d          = StIdle;
      end
      StError: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
